// File: rtl/stencil_fetch.sv
`default_nettype none
// ============================================================================
// Module   : stencil_fetch
// Function : Walks a GRID_W x GRID_H row-major grid RAM and emits one 5-point
//            stencil (C,N,S,E,W) per cell over a valid/ready handshake.
//            Optional macro STENCIL_DIRICHLET_EN: fixed-value walls.
// Revision : 1.0 - initial release
// ============================================================================
module stencil_fetch #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDRESS_WIDTH  = 12,
  parameter int                    GRID_W         = 50,
  parameter int                    GRID_H         = 50,
  parameter logic [DATA_WIDTH-1:0] BOUNDARY_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic [DATA_WIDTH-1:0]    st_c,
  output logic [DATA_WIDTH-1:0]    st_n,
  output logic [DATA_WIDTH-1:0]    st_s,
  output logic [DATA_WIDTH-1:0]    st_e,
  output logic [DATA_WIDTH-1:0]    st_w,
  output logic [ADDRESS_WIDTH-1:0] st_addr,
  output logic [3:0]               st_boundary,
  output logic                     st_last
);

  localparam int c_col_w = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int c_row_w = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [c_col_w-1:0]       c_col_max  = c_col_w'(GRID_W - 1);
  localparam logic [c_row_w-1:0]       c_row_max  = c_row_w'(GRID_H - 1);
  localparam logic [c_col_w-1:0]       c_col_one  = c_col_w'(1);
  localparam logic [c_row_w-1:0]       c_row_one  = c_row_w'(1);
  localparam logic [ADDRESS_WIDTH-1:0] c_row_step = ADDRESS_WIDTH'(GRID_W);
  localparam logic [ADDRESS_WIDTH-1:0] c_addr_one = ADDRESS_WIDTH'(1);
  localparam logic [2:0]               c_ph_one   = 3'd1;

`ifdef STENCIL_DIRICHLET_EN
  localparam bit c_dirichlet = 1'b1;
`else
  localparam bit c_dirichlet = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q,  state_d;
  logic [2:0]               phase_q,  phase_d;
  logic [c_row_w-1:0]       row_q,    row_d;
  logic [c_col_w-1:0]       col_q,    col_d;
  logic [ADDRESS_WIDTH-1:0] centre_q, centre_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0]    c_q, c_d, n_q, n_d, s_q, s_d, e_q, e_d, w_q, w_d;

  logic                     w_top, w_bot, w_left, w_right, w_last;
  logic [ADDRESS_WIDTH-1:0] w_addr_n, w_addr_s, w_addr_e, w_addr_w;
  logic [DATA_WIDTH-1:0]    w_fill;

  assign w_top   = (row_q == '0);
  assign w_bot   = (row_q == c_row_max);
  assign w_left  = (col_q == '0);
  assign w_right = (col_q == c_col_max);
  assign w_last  = w_bot && w_right;

  // Out-of-grid slots re-read the centre so no address ever leaves the grid.
  assign w_addr_n = w_top   ? centre_q : centre_q - c_row_step;
  assign w_addr_s = w_bot   ? centre_q : centre_q + c_row_step;
  assign w_addr_e = w_right ? centre_q : centre_q + c_addr_one;
  assign w_addr_w = w_left  ? centre_q : centre_q - c_addr_one;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    row_d    = row_q;
    col_d    = col_q;
    centre_d = centre_q;
    addr_d   = addr_q;
    c_d      = c_q;
    n_d      = n_q;
    s_d      = s_q;
    e_d      = e_q;
    w_d      = w_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          phase_d  = '0;
          row_d    = '0;
          col_d    = '0;
          centre_d = '0;
          addr_d   = '0;
        end
      end
      S_FETCH: begin
        phase_d = phase_q + c_ph_one;
        // Address issue runs one slot ahead of capture (1-cycle RAM latency).
        case (phase_q)
          3'd0: addr_d = w_addr_n;
          3'd1: begin
            addr_d = w_addr_s;
            c_d    = ram_rdata;
          end
          3'd2: begin
            addr_d = w_addr_e;
            n_d    = ram_rdata;
          end
          3'd3: begin
            addr_d = w_addr_w;
            s_d    = ram_rdata;
          end
          3'd4: e_d = ram_rdata;
          default: begin
            w_d     = ram_rdata;
            phase_d = '0;
            state_d = S_OUT;
          end
        endcase
      end
      S_OUT: begin
        if (st_ready) begin
          if (w_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FETCH;
            phase_d  = '0;
            centre_d = centre_q + c_addr_one;
            addr_d   = centre_q + c_addr_one;
            if (w_right) begin
              col_d = '0;
              row_d = row_q + c_row_one;
            end else begin
              col_d = col_q + c_col_one;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      centre_q <= '0;
      addr_q   <= '0;
      c_q      <= '0;
      n_q      <= '0;
      s_q      <= '0;
      e_q      <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      row_q    <= row_d;
      col_q    <= col_d;
      centre_q <= centre_d;
      addr_q   <= addr_d;
      c_q      <= c_d;
      n_q      <= n_d;
      s_q      <= s_d;
      e_q      <= e_d;
      w_q      <= w_d;
    end
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_OUT);
  assign done     = (state_q == S_DONE);
  assign st_valid = (state_q == S_OUT);
  assign ram_addr = addr_q;
  assign st_addr  = centre_q;
  assign st_last  = st_valid && w_last;

  // Flags are gated so that idle/reset outputs read as all-zero.
  assign st_boundary = st_valid ? {w_top, w_bot, w_right, w_left} : 4'b0000;

  assign w_fill = c_dirichlet ? BOUNDARY_VALUE : c_q;
  assign st_c   = c_q;
  assign st_n   = st_boundary[3] ? w_fill : n_q;
  assign st_s   = st_boundary[2] ? w_fill : s_q;
  assign st_e   = st_boundary[1] ? w_fill : e_q;
  assign st_w   = st_boundary[0] ? w_fill : w_q;

endmodule
`default_nettype wire

// File: tb/tb_stencil_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_stencil_fetch
// Function : Self-checking bench for stencil_fetch: RAM model, cell-level
//            reference model and literal corner checks (STENCIL_DIRICHLET_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stencil_fetch;
  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int GW    = 50;
  localparam int GH    = 50;
  localparam int NCELL = GW * GH;
  localparam logic [DW-1:0] BV = 16'h0007;
`ifdef STENCIL_DIRICHLET_EN
  localparam bit DIRICHLET = 1'b1;
`else
  localparam bit DIRICHLET = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          st_ready  = 1'b1;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy, done, st_valid, st_last;
  logic [AW-1:0] ram_addr, st_addr;
  logic [DW-1:0] st_c, st_n, st_s, st_e, st_w;
  logic [3:0]    st_boundary;

  logic [DW-1:0] mem [0:NCELL-1];

  int n_cmp = 0, n_mis = 0, cyc = 0;
  int pend = -1, launch = 0, done_at = -100, n_xfer = 0, done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= (int'(ram_addr) < NCELL) ? mem[ram_addr] : '0;

  stencil_fetch #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .GRID_W(GW), .GRID_H(GH), .BOUNDARY_VALUE(BV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .st_valid(st_valid), .st_ready(st_ready),
    .st_c(st_c), .st_n(st_n), .st_s(st_s), .st_e(st_e), .st_w(st_w),
    .st_addr(st_addr), .st_boundary(st_boundary), .st_last(st_last)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Neighbour value from the boundary rule: in-grid reads the RAM image.
  function automatic logic [DW-1:0] nb(input bit outside, input int idx, input logic [DW-1:0] c);
    if (!outside) return mem[idx];
    return DIRICHLET ? BV : c;
  endfunction

  // Reference model: one cell in flight; its stencil is due 6 edges after launch.
  initial begin : monitor
    bit            pv, ev;
    int            r, q;
    logic [DW-1:0] ec;
    logic [3:0]    eb;
    forever begin
      @(posedge clk);
      cyc++;
      pv = (pend >= 0) && (cyc - 1 - launch >= 6);
      if (!rst_n) begin
        pend    = -1;
        done_at = -100;
      end else if (pend < 0) begin
        if (start && done_at != cyc - 1) begin
          pend   = 0;
          launch = cyc;
          n_xfer = 0;
        end
      end else if (pv && st_ready) begin
        n_xfer++;
        if (pend == NCELL - 1) begin
          pend    = -1;
          done_at = cyc;
        end else begin
          pend++;
          launch = cyc;
        end
      end
      #1;
      ev = (pend >= 0) && (cyc - launch >= 6);
      check("st_valid", st_valid, ev);
      check("busy", busy, pend >= 0);
      check("done", done, cyc == done_at);
      if (done) done_cnt++;
      if (ev) begin
        r  = pend / GW;
        q  = pend % GW;
        eb = {r == 0, r == GH - 1, q == GW - 1, q == 0};
        ec = mem[pend];
        check("st_addr", st_addr, pend);
        check("st_c", st_c, ec);
        check("st_n", st_n, nb(eb[3], pend - GW, ec));
        check("st_s", st_s, nb(eb[2], pend + GW, ec));
        check("st_e", st_e, nb(eb[1], pend + 1, ec));
        check("st_w", st_w, nb(eb[0], pend - 1, ec));
        check("st_boundary", st_boundary, eb);
        check("st_last", st_last, pend == NCELL - 1);
        check("ram_addr_hold", ram_addr, eb[0] ? pend : pend - 1);
      end
    end
  end

  task automatic wait_cell(input int a, input int limit, output bit found);
    found = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge clk);
      if (st_valid && int'(st_addr) == a) found = 1'b1;
    end
    check($sformatf("reach_cell_%0d", a), found, 1'b1);
  endtask

  task automatic check_st(input string tag, input logic [DW-1:0] c, n, s, e, w,
                          input logic [3:0] b, input bit last);
    check({tag, ".c"}, st_c, c);
    check({tag, ".n"}, st_n, n);
    check({tag, ".s"}, st_s, s);
    check({tag, ".e"}, st_e, e);
    check({tag, ".w"}, st_w, w);
    check({tag, ".boundary"}, st_boundary, b);
    check({tag, ".last"}, st_last, last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctrl"}, {busy, done, st_valid, ram_addr, st_addr, st_boundary, st_last}, '0);
    check({tag, ".data"}, {st_c, st_n, st_s, st_e, st_w}, '0);
  endtask

  initial begin : driver
    bit found;
    int k;
    logic [DW-1:0] f0;
    f0 = DIRICHLET ? BV : 16'd0;
    for (int i = 0; i < NCELL; i++) mem[i] = DW'(i);

    // Reset held with start asserted
    rst_n = 1'b0; start = 1'b1; st_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_hold_busy", busy, 1'b0);
    end

    // Sweep 1: ready always high, stray start mid-sweep
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      @(posedge clk); #2;
      k++;
      if (st_valid) found = 1'b1;
    end
    check("first_valid_edge", k, 6);
    check_st("cell0", 16'd0, f0, 16'd50, 16'd1, f0, 4'b1001, 1'b0);
    wait_cell(20, 400, found);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cell(51, 1000, found);
    check_st("cell51", 16'd51, 16'd1, 16'd101, 16'd52, 16'd50, 4'b0000, 1'b0);
    wait_cell(NCELL - 1, 20000, found);
    check_st("cell2499", 16'd2499, 16'd2449, DIRICHLET ? BV : 16'd2499,
             DIRICHLET ? BV : 16'd2499, 16'd2498, 4'b0110, 1'b1);
    found = 1'b0;
    for (int j = 0; j < 5 && !found; j++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("sweep1_done_seen", found, 1'b1);
    check("sweep1_xfers", n_xfer, NCELL);
    repeat (3) @(negedge clk);
    check("sweep1_done_pulses", done_cnt, 1);

    // Sweep 2: backpressure on cell 5, then reset in phase 3 of cell 10
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cell(5, 200, found);
    st_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", st_valid, 1'b1);
      check("bp_ram_addr", ram_addr, 12'd4);
      check("bp_st_addr", st_addr, 12'd5);
      check_st("bp_cell5", 16'd5, DIRICHLET ? BV : 16'd5, 16'd55, 16'd6, 16'd4, 4'b1000, 1'b0);
    end
    st_ready = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      @(posedge clk); #2;
      k++;
      if (st_valid && st_addr == 12'd6) found = 1'b1;
    end
    check("bp_cell6_gap", k, 7);
    wait_cell(9, 100, found);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("phase3_ram_addr", ram_addr, 12'd11);
    check("phase3_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_fetch_reset");
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cell(0, 20, found);
    check_st("restart_cell0", 16'd0, f0, 16'd50, 16'd1, f0, 4'b1001, 1'b0);

    // Sweep 3: random RAM image, random ready, stray starts
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCELL; i++) mem[i] = DW'($urandom);
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 40000 && !found; j++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      st_ready = ($urandom_range(0, 3) != 0);
      start    = (pend >= 0) && (pend < NCELL - 100) && ($urandom_range(0, 63) == 0);
    end
    start = 1'b0;
    check("rand_done_seen", found, 1'b1);
    check("rand_xfers", n_xfer, NCELL);
    repeat (3) @(negedge clk);
    check("rand_done_pulses", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
